// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with four run-time-selectable test patterns.
// Every output is registered and describes the h/v counter state of the previous en-cycle.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   COLOR_BITS = 4,
    parameter int   CHK_LOG2   = 5,
    localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW         = $clog2(H_TOTAL),
    localparam int  VW         = $clog2(V_TOTAL)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [3*COLOR_BITS-1:0]   solid_rgb,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [COLOR_BITS-1:0]     r,
    output logic [COLOR_BITS-1:0]     g,
    output logic [COLOR_BITS-1:0]     b,
    output logic [HW-1:0]             x,
    output logic [VW-1:0]             y,
    output logic                      line_start,
    output logic                      frame_start
);

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_t;

    localparam int            BAR_W    = H_ACTIVE / 8;
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);

    logic [HW-1:0]         r_h;
    logic [VW-1:0]         r_v;
    logic [7:0]            r_frame_cnt;
    pattern_t              r_mode;
    logic [2:0]            r_bar;
    logic [HW-1:0]         r_bar_px;

    logic                  w_h_wrap;
    logic                  w_v_wrap;
    logic                  w_origin;
    logic                  w_de;
    logic                  w_chk;
    pattern_t              w_mode;
    logic [COLOR_BITS-1:0] w_r;
    logic [COLOR_BITS-1:0] w_g;
    logic [COLOR_BITS-1:0] w_b;

    always_comb begin
        w_h_wrap = (r_h == H_LAST);
        w_v_wrap = (r_v == V_LAST);
        w_origin = (r_h == '0) && (r_v == '0);
        // The mode sampled at the origin already governs the origin pixel itself.
        w_mode   = w_origin ? pattern_t'(mode) : r_mode;
        w_de     = (r_h < H_ACT_L) && (r_v < V_ACT_L);
        w_chk    = 1'(r_h >> CHK_LOG2) ^ 1'(r_v >> CHK_LOG2);
        w_r      = '0;
        w_g      = '0;
        w_b      = '0;
        case (w_mode)
            PAT_BARS: begin
                w_r = {COLOR_BITS{r_bar[2]}};
                w_g = {COLOR_BITS{r_bar[1]}};
                w_b = {COLOR_BITS{r_bar[0]}};
            end
            PAT_CHECKER: begin
                w_r = {COLOR_BITS{w_chk}};
                w_g = {COLOR_BITS{w_chk}};
                w_b = {COLOR_BITS{w_chk}};
            end
            PAT_GRADIENT: begin
                w_r = COLOR_BITS'(r_h >> 2);
                w_g = COLOR_BITS'(r_v >> 2);
                w_b = r_frame_cnt[7 -: COLOR_BITS];
            end
            PAT_SOLID: begin
                {w_r, w_g, w_b} = solid_rgb;
            end
        endcase
        if (!w_de) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
            r_mode      <= PAT_BARS;
            r_bar       <= '0;
            r_bar_px    <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            r_h <= w_h_wrap ? '0 : r_h + HW'(1);
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? '0 : r_v + VW'(1);
            end
            if (w_h_wrap && w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_origin) begin
                r_mode <= w_mode;
            end

            // Bar index tracks h by counting pixels within each bar instead of dividing.
            if (w_h_wrap) begin
                r_bar    <= '0;
                r_bar_px <= '0;
            end else if (r_bar_px == BAR_LAST) begin
                r_bar    <= r_bar + 3'd1;
                r_bar_px <= '0;
            end else begin
                r_bar_px <= r_bar_px + HW'(1);
            end

            hsync       <= ((r_h >= HS_START) && (r_h < HS_END)) ? HS_POL : ~HS_POL;
            vsync       <= ((r_v >= VS_START) && (r_v < VS_END)) ? VS_POL : ~VS_POL;
            de          <= w_de;
            r           <= w_r;
            g           <= w_g;
            b           <= w_b;
            x           <= r_h;
            y           <= r_v;
            line_start  <= (r_h == '0);
            frame_start <= w_origin;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, a tiny mode for frame-level
// behaviour, and an 800x600 positive-polarity override.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default 640x480 instance
    logic        d_rst_n = 1'b0, d_en = 1'b0;
    logic [1:0]  d_mode = 2'd0;
    logic [11:0] d_solid = '0;
    logic        d_hs, d_vs, d_de, d_ls, d_fs;
    logic [3:0]  d_r, d_g, d_b;
    logic [9:0]  d_x, d_y;

    vga_timing_gen u_dflt (
        .clk(clk), .rst_n(d_rst_n), .en(d_en), .mode(d_mode), .solid_rgb(d_solid),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .r(d_r), .g(d_g), .b(d_b),
        .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    // Tiny 24x10 instance, 8-bit colour, 4-pixel checker squares
    logic        s_rst_n = 1'b0, s_en = 1'b0;
    logic [1:0]  s_mode = 2'd0;
    logic [23:0] s_solid = '0;
    logic        s_hs, s_vs, s_de, s_ls, s_fs;
    logic [7:0]  s_r, s_g, s_b;
    logic [4:0]  s_x;
    logic [3:0]  s_y;
    logic [37:0] s_out;
    assign s_out = {s_hs, s_vs, s_de, s_r, s_g, s_b, s_x, s_y, s_ls, s_fs};

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .COLOR_BITS(8), .CHK_LOG2(2)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .en(s_en), .mode(s_mode), .solid_rgb(s_solid),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .r(s_r), .g(s_g), .b(s_b),
        .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    // 800x600 positive-polarity instance
    logic        l_rst_n = 1'b0, l_en = 1'b0;
    logic [1:0]  l_mode = 2'd0;
    logic [11:0] l_solid = '0;
    logic        l_hs, l_vs, l_de, l_ls, l_fs;
    logic [3:0]  l_r, l_g, l_b;
    logic [10:0] l_x;
    logic [9:0]  l_y;

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_large (
        .clk(clk), .rst_n(l_rst_n), .en(l_en), .mode(l_mode), .solid_rgb(l_solid),
        .hsync(l_hs), .vsync(l_vs), .de(l_de), .r(l_r), .g(l_g), .b(l_b),
        .x(l_x), .y(l_y), .line_start(l_ls), .frame_start(l_fs)
    );

    int          bx [12] = '{79, 80, 159, 160, 240, 320, 400, 480, 559, 560, 639, 640};
    logic [11:0] bv [12] = '{12'h000, 12'h00F, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00,
                             12'hF0F, 12'hFF0, 12'hFF0, 12'hFFF, 12'hFFF, 12'h000};

    int          j, fall1, fall2, low_w, fall_x, e, per, de_cnt, vs_low, vs_x, vs_y, found;
    logic        prev;
    logic [63:0] snap;
    logic [11:0] blank_rgb;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        // Reset state
        check("d_rst_hsync", d_hs, 1'b1);
        check("d_rst_vsync", d_vs, 1'b1);
        check("d_rst_de", d_de, 1'b0);
        check("d_rst_rgb", {d_r, d_g, d_b}, 12'h000);
        check("d_rst_xy", {d_x, d_y}, 20'h0);
        check("d_rst_pulses", {d_ls, d_fs}, 2'b00);
        check("l_rst_hsync", l_hs, 1'b0);
        check("l_rst_vsync", l_vs, 1'b0);

        // First en cycle after release
        d_rst_n = 1'b1;
        d_en    = 1'b1;
        tick();
        check("d_first_fs", d_fs, 1'b1);
        check("d_first_ls", d_ls, 1'b1);
        check("d_first_de", d_de, 1'b1);
        check("d_first_xy", {d_x, d_y}, 20'h0);
        check("d_first_rgb", {d_r, d_g, d_b}, 12'h000);

        // Colour bars on line 0
        j = 0;
        for (int p = 1; p <= 640; p++) begin
            tick();
            if (j < 12 && p == bx[j]) begin
                check($sformatf("d_bar_x%0d", p), {d_r, d_g, d_b}, bv[j]);
                j++;
            end
        end
        check("d_x_640", d_x, 10'd640);
        check("d_de_640", d_de, 1'b0);
        check("d_ls_640", d_ls, 1'b0);

        // hsync position, width and period
        fall1 = -1; fall2 = -1; low_w = 0; fall_x = -1;
        prev = d_hs;
        for (int i = 0; i < 2000 && fall2 < 0; i++) begin
            tick();
            if (prev && !d_hs) begin
                if (fall1 < 0) begin
                    fall1  = i;
                    fall_x = int'(d_x);
                end else begin
                    fall2 = i;
                end
            end
            if (!d_hs && fall1 >= 0 && fall2 < 0) low_w++;
            prev = d_hs;
        end
        check("d_hs_start_x", fall_x, 656);
        check("d_hs_width", low_w, 96);
        check("d_hs_period", fall2 - fall1, 800);
        check("d_vs_idle", d_vs, 1'b1);

        // en low holds everything
        d_en = 1'b0;
        snap = {d_hs, d_vs, d_de, d_r, d_g, d_b, d_x, d_y, d_ls, d_fs};
        tick(); tick(); tick();
        check("d_en_hold", {d_hs, d_vs, d_de, d_r, d_g, d_b, d_x, d_y, d_ls, d_fs}, snap);

        // Mode written mid-frame only takes effect at the next frame
        s_rst_n = 1'b1;
        s_en    = 1'b1;
        tick();
        for (int i = 0; i < 28; i++) begin
            if (i == 8) s_mode = 2'd2;
            tick();
        end
        check("s_mid_xy", {s_x, s_y}, {5'd4, 4'd1});
        check("s_mid_still_bars", {s_r, s_g, s_b}, 24'h00FF00);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (s_fs) found = 1;
        end
        check("s_fs_seen", found, 1);
        check("s_grad_origin", {s_r, s_g, s_b}, 24'h000001);

        // One full frame: period, DE area, vsync placement
        per = 0; de_cnt = s_de ? 1 : 0; vs_low = 0; vs_x = -1; vs_y = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (s_fs) begin
                per = i;
                break;
            end
            if (i == 4) check("s_grad_x4", {s_r, s_g, s_b}, 24'h010001);
            if (s_de) de_cnt++;
            if (!s_vs) begin
                if (vs_low == 0) begin
                    vs_x = int'(s_x);
                    vs_y = int'(s_y);
                end
                vs_low++;
            end
        end
        check("s_frame_period", per, 240);
        check("s_de_count", de_cnt, 96);
        check("s_vs_width", vs_low, 48);
        check("s_vs_start_x", vs_x, 0);
        check("s_vs_start_y", vs_y, 7);
        check("s_grad_frame2", {s_r, s_g, s_b}, 24'h000002);

        // Checker pattern from the following frame
        s_mode = 2'd1;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (s_fs) found = 1;
        end
        check("s_chk_fs_seen", found, 1);
        check("s_chk_x0", {s_r, s_g, s_b}, 24'h000000);
        tick(); tick(); tick(); tick();
        check("s_chk_x4", {s_r, s_g, s_b}, 24'hFFFFFF);

        // en at 1-in-3 duty: outputs hold, sync measured in en-cycles unchanged
        fall1 = -1; fall2 = -1; low_w = 0; e = 0;
        prev = s_hs;
        for (int i = 0; i < 300 && fall2 < 0; i++) begin
            s_en = (i % 3 == 0);
            snap = 64'(s_out);
            tick();
            if (!s_en) begin
                check("s_en_hold", s_out, snap);
            end else begin
                e++;
                if (prev && !s_hs) begin
                    if (fall1 < 0) fall1 = e;
                    else fall2 = e;
                end
                if (!s_hs && fall1 >= 0 && fall2 < 0) low_w++;
                prev = s_hs;
            end
        end
        s_en = 1'b1;
        check("s_en_hs_width", low_w, 3);
        check("s_en_hs_period", fall2 - fall1, 24);

        // Asynchronous reset inside both sync pulses
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (s_x == 5'd20 && s_y == 4'd7) found = 1;
        end
        check("s_rst_point_seen", found, 1);
        check("s_pre_rst_sync", {s_hs, s_vs}, 2'b00);
        s_rst_n = 1'b0;
        #1;
        check("s_rst_sync", {s_hs, s_vs}, 2'b11);
        check("s_rst_de", s_de, 1'b0);
        check("s_rst_rgb", {s_r, s_g, s_b}, 24'h0);
        check("s_rst_xy", {s_x, s_y}, 9'h0);
        check("s_rst_pulses", {s_ls, s_fs}, 2'b00);
        tick();
        s_rst_n = 1'b1;
        tick();
        check("s_post_rst_fs", s_fs, 1'b1);
        check("s_post_rst_de", s_de, 1'b1);
        check("s_post_rst_xy", {s_x, s_y}, 9'h0);
        s_en = 1'b0;

        // 800x600 override, solid colour
        l_mode  = 2'd3;
        l_solid = 12'h5A3;
        l_rst_n = 1'b1;
        l_en    = 1'b1;
        tick();
        check("l_first_fs", l_fs, 1'b1);
        check("l_solid_x0", {l_r, l_g, l_b}, 12'h5A3);
        l_solid = 12'h1C7;
        tick();
        check("l_solid_live", {l_r, l_g, l_b}, 12'h1C7);
        fall1 = -1; fall2 = -1; low_w = 0; fall_x = -1;
        blank_rgb = 12'hFFF;
        prev = l_hs;
        for (int i = 0; i < 2600 && fall2 < 0; i++) begin
            tick();
            if (l_x == 11'd800 && l_y == 10'd0) blank_rgb = {l_r, l_g, l_b};
            if (!prev && l_hs) begin
                if (fall1 < 0) begin
                    fall1  = i;
                    fall_x = int'(l_x);
                end else begin
                    fall2 = i;
                end
            end
            if (l_hs && fall1 >= 0 && fall2 < 0) low_w++;
            prev = l_hs;
        end
        check("l_hs_start_x", fall_x, 840);
        check("l_hs_width", low_w, 128);
        check("l_hs_period", fall2 - fall1, 1056);
        check("l_blank_rgb", blank_rgb, 12'h000);
        check("l_vs_idle", l_vs, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
